alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU-control decoder.
- Decodes alu_op, funct3, funct7 and op5 for the full RV32I ALU set plus the RV32M multiply and divide ops.
- Executes the decoded operation on XLEN-bit operands behind a valid/ready handshake.
- Basic ops complete in 1 cycle; multiply and divide iterate. Sits in the execute stage of the multicycle core, between operand muxing and writeback.

---
 rtl/alu_exec_pkg.sv | 41 ++++
 rtl/alu_exec_if.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 137 +++++++++++++
 rtl/alu_exec_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the execute unit: ALU op classes, decoded function codes,
// FSM states and the RV32M funct3 encodings.
package alu_exec_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [4:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND,
        FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_DIV, FN_DIVU, FN_REM, FN_REMU
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } exec_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic fn_is_mul(alu_fn_e fn);
        return fn inside {FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU};
    endfunction

    function automatic logic fn_is_div(alu_fn_e fn);
        return fn inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation/result bus of the execute unit: request side (master) and the unit (slave).
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            op5;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            out_err;

    modport master (
        output in_valid, op5, funct3, funct7_5, funct7_0, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, out_err
    );

    modport slave (
        input  in_valid, op5, funct3, funct7_5, funct7_0, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, zero, out_err
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (radix-2 shift-add) and, with ALU_EXEC_DIV_EN, restoring divide.
// Works on operand magnitudes; signs are restored on the final result.
module alu_muldiv_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_fn_e         fn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CNT_W = $clog2(XLEN);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, mul_step, prod_fix;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    alu_fn_e           fn_q, fn_d;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     add_hi;
`ifdef ALU_EXEC_DIV_EN
    logic              neg_rem_q, neg_rem_d;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic              fits;
    logic [XLEN-1:0]   quo, rem;
`endif

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (fn)
            FN_MUL, FN_MULH, FN_DIV, FN_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            FN_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed & a[XLEN-1];
        b_neg = b_signed & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        add_hi   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {add_hi, acc_q[XLEN-1:1]};
        acc_step = mul_step;
`ifdef ALU_EXEC_DIV_EN
        shifted  = acc_q[2*XLEN-1:XLEN-1];
        diff     = {1'b0, shifted} - {2'b00, opnd_q};
        fits     = ~diff[XLEN+1];
        div_step = {(fits ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc_q[XLEN-2:0], fits};
        if (fn_is_div(fn_q)) acc_step = div_step;
`endif
    end

    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        res      = (fn_q == FN_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_EXEC_DIV_EN
        quo = acc_step[XLEN-1:0];
        rem = acc_step[2*XLEN-1:XLEN];
        case (fn_q)
            FN_DIV, FN_DIVU: res = neg_q ? -quo : quo;
            FN_REM, FN_REMU: res = neg_rem_q ? -rem : rem;
            default: ;
        endcase
`endif
    end

    assign done = busy_q && (cnt_q == CNT_W'(XLEN-1));
    assign busy = busy_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        neg_d  = neg_q;
        fn_d   = fn_q;
`ifdef ALU_EXEC_DIV_EN
        neg_rem_d = neg_rem_q;
`endif
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            fn_d   = fn;
            neg_d  = a_neg ^ b_neg;
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
`ifdef ALU_EXEC_DIV_EN
            neg_rem_d = a_neg;
`endif
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            fn_q   <= FN_ADD;
`ifdef ALU_EXEC_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            neg_q  <= neg_d;
            fn_q   <= fn_d;
`ifdef ALU_EXEC_DIV_EN
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/RV32M execute stage with valid/ready handshake.
// Define ALU_EXEC_DIV_EN to build the divider; otherwise DIV/REM complete with out_err.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    exec_state_e        state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    alu_fn_e            fn;
    logic               dec_err;
    logic [XLEN-1:0]    basic_res;
    logic [SHAMT_W-1:0] shamt;
    logic               in_ready;
    logic               md_start, md_busy, md_done;
    logic [XLEN-1:0]    md_res;
`ifdef ALU_EXEC_DIV_EN
    logic               div_special;
    logic [XLEN-1:0]    div_res;
    logic               is_rem, b_zero, ovf;
`endif

    always_comb begin
        fn      = FN_ADD;
        dec_err = 1'b0;
        case (alu_op_e'(bus.alu_op))
            ALU_ADD:  fn = FN_ADD;
            ALU_SUB:  fn = FN_SUB;
            ALU_RSVD: dec_err = 1'b1;
            default: begin
                if (bus.op5 && bus.funct7_0) begin
                    case (bus.funct3)
                        F3_MUL:    fn = FN_MUL;
                        F3_MULH:   fn = FN_MULH;
                        F3_MULHSU: fn = FN_MULHSU;
                        F3_MULHU:  fn = FN_MULHU;
                        F3_DIV:    fn = FN_DIV;
                        F3_DIVU:   fn = FN_DIVU;
                        F3_REM:    fn = FN_REM;
                        default:   fn = FN_REMU;
                    endcase
                end else begin
                    case (bus.funct3)
                        3'b000:  fn = (bus.op5 && bus.funct7_5) ? FN_SUB : FN_ADD;
                        3'b001:  fn = FN_SLL;
                        3'b010:  fn = FN_SLT;
                        3'b011:  fn = FN_SLTU;
                        3'b100:  fn = FN_XOR;
                        3'b101:  fn = bus.funct7_5 ? FN_SRA : FN_SRL;
                        3'b110:  fn = FN_OR;
                        default: fn = FN_AND;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        shamt = bus.b[SHAMT_W-1:0];
        case (fn)
            FN_SUB:  basic_res = bus.a - bus.b;
            FN_SLL:  basic_res = bus.a << shamt;
            FN_SLT:  basic_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            FN_SLTU: basic_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            FN_XOR:  basic_res = bus.a ^ bus.b;
            FN_SRL:  basic_res = bus.a >> shamt;
            FN_SRA:  basic_res = $signed(bus.a) >>> shamt;
            FN_OR:   basic_res = bus.a | bus.b;
            FN_AND:  basic_res = bus.a & bus.b;
            default: basic_res = bus.a + bus.b;
        endcase
    end

`ifdef ALU_EXEC_DIV_EN
    // Divide-by-zero and signed overflow have fixed answers and skip the iterative divider
    always_comb begin
        is_rem      = (fn == FN_REM) || (fn == FN_REMU);
        b_zero      = (bus.b == '0);
        ovf         = ((fn == FN_DIV) || (fn == FN_REM)) &&
                      (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
        div_special = b_zero || ovf;
        if (b_zero) div_res = is_rem ? bus.a : '1;
        else        div_res = is_rem ? '0 : bus.a;
    end
`endif

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .fn    (fn),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res)
    );

    assign in_ready = (state_q == ST_IDLE) && !md_busy;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready) begin
                    state_d = ST_DONE;
                    err_d   = dec_err;
                    if (fn_is_mul(fn)) begin
                        md_start = 1'b1;
                        state_d  = ST_MUL;
                    end else if (fn_is_div(fn)) begin
`ifdef ALU_EXEC_DIV_EN
                        if (div_special) begin
                            result_d = div_res;
                        end else begin
                            md_start = 1'b1;
                            state_d  = ST_DIV;
                        end
`else
                        result_d = '0;
                        err_d    = 1'b1;
`endif
                    end else begin
                        result_d = basic_res;
                    end
                end
            end
`ifdef ALU_EXEC_DIV_EN
            ST_MUL, ST_DIV: begin
`else
            ST_MUL: begin
`endif
                if (md_done) begin
                    result_d = md_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake/reset sequences and
// random ops checked against a 64-bit arithmetic reference model.
module tb_alu_exec_unit;
    localparam int XLEN     = 32;
    localparam int LONG_LAT = XLEN + 1;
    localparam int MAX_WAIT = 100;

    typedef struct {
        logic [1:0]      alu_op;
        logic            op5;
        logic [2:0]      funct3;
        logic            funct7_5;
        logic            funct7_0;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp_result;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic vec_t mkVec(input logic [1:0] op, input logic op5, input logic [2:0] f3,
                                   input logic f75, input logic f70, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] r, input logic err,
                                   input int lat);
        vec_t v;
        v.alu_op = op; v.op5 = op5; v.funct3 = f3; v.funct7_5 = f75; v.funct7_0 = f70;
        v.a = a; v.b = b; v.exp_result = r; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Reference model: RISC-V semantics evaluated with 64-bit integer arithmetic
    function automatic void refModel(input logic [1:0] op, input logic op5, input logic [2:0] f3,
                                     input logic f75, input logic f70, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic err, output int lat);
        longint sa, sb, ua, ub, q, m;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r = '0; err = 1'b0; lat = 1;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else if (op == 2'b11) begin r = a + b; err = 1'b1; end
        else if (op5 && f70) begin
            if (!f3[2]) begin
                lat = LONG_LAT;
                case (f3[1:0])
                    2'd0, 2'd1: p = sa * sb;
                    2'd2:       p = sa * ub;
                    default:    p = ua * ub;
                endcase
                r = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
            end else begin
`ifdef ALU_EXEC_DIV_EN
                if (b == 0) r = f3[1] ? a : 32'hFFFF_FFFF;
                else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'h0 : a;
                else begin
                    lat = LONG_LAT;
                    q = f3[0] ? ua / ub : sa / sb;
                    m = f3[0] ? ua % ub : sa % sb;
                    r = f3[1] ? m[31:0] : q[31:0];
                end
`else
                r = '0; err = 1'b1;
`endif
            end
        end else begin
            case (f3)
                3'd0:    r = (op5 && f75) ? a - b : a + b;
                3'd1:    r = a << b[4:0];
                3'd2:    r = {31'b0, (sa < sb)};
                3'd3:    r = {31'b0, (a < b)};
                3'd4:    r = a ^ b;
                3'd5: begin
                    q = sa >>> b[4:0];
                    r = f75 ? q[31:0] : a >> b[4:0];
                end
                3'd6:    r = a | b;
                default: r = a & b;
            endcase
        end
    endfunction

    // Offers one op, waits for acceptance, then counts cycles until out_valid
    task automatic applyStimulus(input vec_t v, output int lat);
        int guard;
        bus.alu_op = v.alu_op; bus.op5 = v.op5; bus.funct3 = v.funct3;
        bus.funct7_5 = v.funct7_5; bus.funct7_0 = v.funct7_0;
        bus.a = v.a; bus.b = v.b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < MAX_WAIT) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= MAX_WAIT) checkOutput("in_ready_timeout", 64'(guard), 64'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consumeResult();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        applyStimulus(v, lat);
        checkOutput({tag, "_result"}, 64'(bus.result), 64'(v.exp_result));
        checkOutput({tag, "_zero"}, 64'(bus.zero), 64'(v.exp_result == 0));
        checkOutput({tag, "_err"}, 64'(bus.out_err), 64'(v.exp_err));
        checkOutput({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        consumeResult();
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [31:0] r;
        logic err;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_op = 2'b00; bus.op5 = 1'b0;
        bus.funct3 = 3'b0; bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_result", 64'(bus.result), 64'(0));
        checkOutput("reset_zero", 64'(bus.zero), 64'(1));
        checkOutput("reset_err", 64'(bus.out_err), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mkVec(2'b00, 0, 3'b000, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1));
        vecs.push_back(mkVec(2'b01, 0, 3'b000, 0, 0, 32'd9, 32'd9, 32'd0, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b101, 1, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b101, 0, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1));
        vecs.push_back(mkVec(2'b10, 0, 3'b101, 1, 0, 32'h8000_0000, 32'd36, 32'hF800_0000, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b000, 1, 0, 32'd10, 32'd3, 32'd7, 0, 1));
        vecs.push_back(mkVec(2'b10, 0, 3'b000, 1, 0, 32'd10, 32'd3, 32'd13, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b001, 0, 0, 32'h0000_0003, 32'd4, 32'h0000_0030, 0, 1));
        vecs.push_back(mkVec(2'b11, 0, 3'b000, 0, 0, 32'd3, 32'd4, 32'd7, 1, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b000, 0, 1, 32'd7, 32'd6, 32'd42, 0, LONG_LAT));
        vecs.push_back(mkVec(2'b10, 1, 3'b001, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, LONG_LAT));
        vecs.push_back(mkVec(2'b10, 1, 3'b011, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, LONG_LAT));
        vecs.push_back(mkVec(2'b10, 1, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, LONG_LAT));
`ifdef ALU_EXEC_DIV_EN
        vecs.push_back(mkVec(2'b10, 1, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, LONG_LAT));
        vecs.push_back(mkVec(2'b10, 1, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, LONG_LAT));
        vecs.push_back(mkVec(2'b10, 1, 3'b101, 0, 1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b111, 0, 1, 32'h0000_1234, 32'd0, 32'h0000_1234, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b100, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b110, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b101, 0, 1, 32'd10, 32'd3, 32'd3, 0, LONG_LAT));
`else
        vecs.push_back(mkVec(2'b10, 1, 3'b101, 0, 1, 32'd10, 32'd3, 32'd0, 1, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 1));
        vecs.push_back(mkVec(2'b10, 1, 3'b111, 0, 1, 32'h0000_1234, 32'd0, 32'd0, 1, 1));
`endif
        for (int i = 0; i < vecs.size(); i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: result held while out_ready is low, and no accept on the take cycle
        v = mkVec(2'b00, 0, 3'b000, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1);
        applyStimulus(v, lat);
        checkOutput("bp_latency", 64'(lat), 64'(1));
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d_out_valid", k), 64'(bus.out_valid), 64'(1));
            checkOutput($sformatf("bp%0d_result", k), 64'(bus.result), 64'(12));
            checkOutput($sformatf("bp%0d_zero", k), 64'(bus.zero), 64'(0));
            checkOutput($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("take_no_accept_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("take_no_accept_in_ready", 64'(bus.in_ready), 64'(1));

        // Reset in the middle of a multiply abandons it
        bus.alu_op = 2'b10; bus.op5 = 1'b1; bus.funct3 = 3'b000; bus.funct7_0 = 1'b1;
        bus.funct7_5 = 1'b0; bus.a = 32'd7; bus.b = 32'd6; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("mid_mul_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("rst_mid_result", 64'(bus.result), 64'(0));
        checkOutput("rst_mid_zero", 64'(bus.zero), 64'(1));
        checkOutput("rst_mid_err", 64'(bus.out_err), 64'(0));
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_mid_abandoned", 64'(bus.out_valid), 64'(0));

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            v.alu_op   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            v.op5      = ($urandom_range(0, 3) != 0);
            v.funct3   = 3'($urandom_range(0, 7));
            v.funct7_5 = 1'($urandom_range(0, 1));
            v.funct7_0 = 1'($urandom_range(0, 1));
            v.a        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            sel = $urandom_range(0, 7);
            v.b        = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 50)) : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                v.a = 32'h8000_0000;
                v.b = 32'hFFFF_FFFF;
            end
            refModel(v.alu_op, v.op5, v.funct3, v.funct7_5, v.funct7_0, v.a, v.b, r, err, lat);
            v.exp_result = r;
            v.exp_err    = err;
            v.exp_lat    = lat;
            runVector(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
